// File: rtl/cov_stream.sv
// Streaming 3-axis mean/covariance over N = 2^LOG2N points: buffer points, register means,
// accumulate centred products one point per cycle, then scale by 1/N. Results held until out_ready.
module cov_stream #(
  parameter int DW    = 10,
  parameter int LOG2N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DW-1:0]          data_in_x,
  input  logic signed [DW-1:0]          data_in_y,
  input  logic signed [DW-1:0]          data_in_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DW+LOG2N-1:0]    mean_x,
  output logic signed [DW+LOG2N-1:0]    mean_y,
  output logic signed [DW+LOG2N-1:0]    mean_z,
  output logic signed [2*DW+1:0]        covXX,
  output logic signed [2*DW+1:0]        covXY,
  output logic signed [2*DW+1:0]        covXZ,
  output logic signed [2*DW+1:0]        covYY,
  output logic signed [2*DW+1:0]        covYZ,
  output logic signed [2*DW+1:0]        covZZ,
  output logic                          busy
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = DW + LOG2N;
  localparam int OW = 2 * DW + 2;
  localparam int AW = OW + LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MEAN, S_ACC, S_SCALE, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [LOG2N-1:0]      r_cnt;
  logic signed [SW-1:0]  r_sum  [3];
  logic signed [SW-1:0]  r_mean [3];
  logic signed [AW-1:0]  r_acc  [6];
  logic signed [OW-1:0]  r_cov  [6];
  logic signed [DW-1:0]  r_buf  [3][N];
  logic signed [DW-1:0]  w_in   [3];
  logic signed [AW-1:0]  w_d    [3];
  logic signed [AW-1:0]  w_p    [6];

  assign w_in[0] = data_in_x;
  assign w_in[1] = data_in_y;
  assign w_in[2] = data_in_z;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && r_cnt == CNT_LAST) w_next = S_MEAN;
      end
      S_MEAN:  w_next = S_ACC;
      S_ACC:   if (r_cnt == CNT_LAST) w_next = S_SCALE;
      S_SCALE: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Differences are formed at accumulator width: |p - mean| <= 2^DW, so each product fits in AW bits.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_d[a] = {{(AW-DW){r_buf[a][r_cnt][DW-1]}}, r_buf[a][r_cnt]}
             - {{(AW-SW){r_mean[a][SW-1]}}, r_mean[a]};
    end
    w_p[0] = w_d[0] * w_d[0];
    w_p[1] = w_d[0] * w_d[1];
    w_p[2] = w_d[0] * w_d[2];
    w_p[3] = w_d[1] * w_d[1];
    w_p[4] = w_d[1] * w_d[2];
    w_p[5] = w_d[2] * w_d[2];
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && in_valid) begin
      for (int a = 0; a < 3; a++) r_buf[a][r_cnt] <= w_in[a];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int a = 0; a < 3; a++) begin
        r_sum[a]  <= '0;
        r_mean[a] <= '0;
      end
      for (int k = 0; k < 6; k++) begin
        r_acc[k] <= '0;
        r_cov[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            for (int a = 0; a < 3; a++) r_sum[a] <= '0;
            for (int k = 0; k < 6; k++) r_acc[k] <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            for (int a = 0; a < 3; a++)
              r_sum[a] <= r_sum[a] + {{LOG2N{w_in[a][DW-1]}}, w_in[a]};
          end
        end
        S_MEAN: begin
          r_cnt <= '0;
          for (int a = 0; a < 3; a++) r_mean[a] <= r_sum[a] >>> LOG2N;
        end
        S_ACC: begin
          r_cnt <= r_cnt + 1'b1;
          for (int k = 0; k < 6; k++) r_acc[k] <= r_acc[k] + w_p[k];
        end
        S_SCALE: begin
          for (int k = 0; k < 6; k++) r_cov[k] <= OW'(r_acc[k] >>> LOG2N);
        end
        default: ;
      endcase
    end
  end

  assign mean_x = r_mean[0];
  assign mean_y = r_mean[1];
  assign mean_z = r_mean[2];
  assign covXX  = r_cov[0];
  assign covXY  = r_cov[1];
  assign covXZ  = r_cov[2];
  assign covYY  = r_cov[3];
  assign covYZ  = r_cov[4];
  assign covZZ  = r_cov[5];

endmodule

// File: tb/tb_cov_stream.sv
// Randomized and directed bench for cov_stream against an arithmetic mean/covariance model.
module tb_cov_stream;

  localparam int DW    = 10;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int OW    = 2 * DW + 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DW-1:0]       data_in_x, data_in_y, data_in_z;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [DW+LOG2N-1:0] mean_x, mean_y, mean_z;
  logic signed [OW-1:0]       covXX, covXY, covXZ, covYY, covYZ, covZZ;
  logic                       busy;

  int     n_chk  = 0;
  int     n_fail = 0;
  int     cyc    = 0;
  int     pts [3][N];
  longint em [3];
  longint ec [6];

  cov_stream #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .data_in_x(data_in_x), .data_in_y(data_in_y), .data_in_z(data_in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .mean_x(mean_x), .mean_y(mean_y), .mean_z(mean_z),
    .covXX(covXX), .covXY(covXY), .covXZ(covXZ),
    .covYY(covYY), .covYZ(covYZ), .covZZ(covZZ),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a);
    longint q;
    q = a / N;
    if ((a % N) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Means are floor(sum/N); covariances are floor(sum of centred products / N).
  task automatic compute_model();
    longint s;
    int pa [6] = '{0, 0, 0, 1, 1, 2};
    int pb [6] = '{0, 1, 2, 1, 2, 2};
    for (int a = 0; a < 3; a++) begin
      s = 0;
      for (int i = 0; i < N; i++) s += pts[a][i];
      em[a] = fdiv(s);
    end
    for (int k = 0; k < 6; k++) begin
      s = 0;
      for (int i = 0; i < N; i++)
        s += (longint'(pts[pa[k]][i]) - em[pa[k]]) * (longint'(pts[pb[k]][i]) - em[pb[k]]);
      ec[k] = fdiv(s);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_mean_x"}, mean_x, em[0]);
    chk({tag, "_mean_y"}, mean_y, em[1]);
    chk({tag, "_mean_z"}, mean_z, em[2]);
    chk({tag, "_covXX"}, covXX, ec[0]);
    chk({tag, "_covXY"}, covXY, ec[1]);
    chk({tag, "_covXZ"}, covXZ, ec[2]);
    chk({tag, "_covYY"}, covYY, ec[3]);
    chk({tag, "_covYZ"}, covYZ, ec[4]);
    chk({tag, "_covZZ"}, covZZ, ec[5]);
  endtask

  task automatic feed(input int gap_a, input int gap_b, input int glen, input bit rnd, output int k);
    k = 0;
    for (int i = 0; i < N; i++) begin
      int g;
      int t;
      g = (i == gap_a || i == gap_b) ? glen : 0;
      if (rnd) g = $urandom_range(2, 0);
      repeat (g) begin
        in_valid  = 1'b0;
        data_in_x = DW'($urandom);
        data_in_y = DW'($urandom);
        data_in_z = DW'($urandom);
        @(negedge clk);
      end
      in_valid  = 1'b1;
      data_in_x = DW'(pts[0][i]);
      data_in_y = DW'(pts[1][i]);
      data_in_z = DW'(pts[2][i]);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("in_ready_timeout", in_ready, 1);
        break;
      end
      @(negedge clk);
      k = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_set(input int gap_a, input int gap_b, input int glen, input bit rnd,
                         input int bp, input bit poke, input bit started);
    int k;
    int t;
    if (!started) begin
      check_outputs("idle_hold");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk("load_busy", busy, 1);
    check_outputs("load_hold");
    compute_model();
    feed(gap_a, gap_b, glen, rnd, k);
    chk("mean_in_ready", in_ready, 0);
    t = 0;
    while (!out_valid && t < 100) begin
      start = (poke && t == 4);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk("out_valid_rise", out_valid, 1);
    chk("latency", cyc - k, N + 2);
    chk("done_in_ready", in_ready, 0);
    check_outputs("done");
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      check_outputs("bp");
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in_x = '0; data_in_y = '0; data_in_z = '0;
    for (int a = 0; a < 3; a++) em[a] = 0;
    for (int k = 0; k < 6; k++) ec[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    check_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    // constant points
    for (int i = 0; i < N; i++) begin pts[0][i] = 1; pts[1][i] = 2; pts[2][i] = 3; end
    run_set(-1, -1, 0, 0, 0, 0, 0);
    chk("t1_mean_x", mean_x, 1);
    chk("t1_mean_z", mean_z, 3);
    chk("t1_covXX", covXX, 0);

    // ramp, without and with input stalls
    for (int i = 0; i < N; i++) begin pts[0][i] = i; pts[1][i] = -i; pts[2][i] = 0; end
    run_set(-1, -1, 0, 0, 0, 0, 0);
    chk("t2_mean_x", mean_x, 7);
    chk("t2_mean_y", mean_y, -8);
    chk("t2_covXX", covXX, 21);
    chk("t2_covYY", covYY, 21);
    chk("t2_covXY", covXY, -21);
    run_set(5, 12, 3, 0, 0, 0, 0);
    chk("t3_covXY", covXY, -21);
    chk("t3_mean_y", mean_y, -8);

    // output backpressure with a start pulse during ACC
    for (int i = 0; i < N; i++) begin pts[0][i] = 3 * i - 20; pts[1][i] = i * i; pts[2][i] = 7 - i; end
    run_set(-1, -1, 0, 0, 10, 1, 0);

    // reset mid-ACC, then release with start held high
    for (int i = 0; i < N; i++) begin pts[0][i] = 1; pts[1][i] = 2; pts[2][i] = 3; end
    begin
      int k;
      check_outputs("pre_rst_hold");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(-1, -1, 0, 0, k);
      repeat (6) @(negedge clk);
      chk("acc_busy", busy, 1);
      rst = 1'b0;
      #1;
      for (int a = 0; a < 3; a++) em[a] = 0;
      for (int j = 0; j < 6; j++) ec[j] = 0;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      check_outputs("midrst");
      @(negedge clk);
      start = 1'b1;
      #2 rst = 1'b1;
      #1 chk("rel_busy", busy, 0);
      @(negedge clk);
      start = 1'b0;
      run_set(-1, -1, 0, 0, 0, 0, 1);
      chk("t5_mean_y", mean_y, 2);
      chk("t5_covZZ", covZZ, 0);
    end

    // extremes
    for (int i = 0; i < N; i++) begin
      pts[0][i] = (i < N / 2) ? -512 : 511;
      pts[1][i] = pts[0][i];
      pts[2][i] = pts[0][i];
    end
    run_set(-1, -1, 0, 1, 2, 0, 0);
    chk("t6_mean_x", mean_x, -1);
    chk("t6_covXX", covXX, 261632);
    chk("t6_covYZ", covYZ, 261632);

    // random sets
    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < 3; a++)
        for (int i = 0; i < N; i++) pts[a][i] = int'($urandom_range(1023, 0)) - 512;
      run_set(-1, -1, 0, 1, int'($urandom_range(4, 0)), s[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cov_stream.md
COV_STREAM -- requirements
Module: cov_stream

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DW, default 10: signed width of each input coordinate.
REQ-003 Parameter LOG2N, default 4: log2 of the number of points per set, N = 2^LOG2N, legal range 1..6.
REQ-004 Derived width OW = 2*DW+2: width of the covariance outputs. Derived width AW = OW+LOG2N: width of the internal accumulators.
REQ-005 Port clk, input, 1 bit: clock; all state updates on posedge.
REQ-006 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 Port start, input, 1 bit: begin a new point set; sampled only in IDLE.
REQ-008 Port in_valid, input, 1 bit: data_in_x, data_in_y and data_in_z are valid.
REQ-009 Port in_ready, output, 1 bit: block accepts a point; high only in LOAD.
REQ-010 Ports data_in_x, data_in_y and data_in_z, input, DW bits each: signed point coordinates.
REQ-011 Port out_valid, output, 1 bit: results are valid; high only in DONE.
REQ-012 Port out_ready, input, 1 bit: consumer takes the results.
REQ-013 Ports mean_x, mean_y and mean_z, output, DW+LOG2N bits each, signed: per-axis means.
REQ-014 Ports covXX, covXY, covXZ, covYY, covYZ and covZZ, output, OW bits each, signed: covariance terms.
REQ-015 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, MEAN, ACC, SCALE and DONE.
- IDLE->LOAD on start.
- LOAD->MEAN after the Nth accepted point.
- MEAN->ACC after 1 cycle.
- ACC->SCALE after N cycles.
- SCALE->DONE after 1 cycle.
- DONE->IDLE on out_ready.
REQ-017 A point SHALL be accepted on a posedge only when in_valid and in_ready are both high; gaps in in_valid stall LOAD with no loss of points.
REQ-018 On entry to LOAD, the sums, the accumulators and the point counter SHALL clear to 0.
REQ-019 Accepted point i (0..N-1) SHALL be stored in buffer slot i; each of the three per-axis sums, of width DW+LOG2N, SHALL add its own coordinate.
REQ-020 MEAN SHALL register each mean as its sum arithmetically shifted right by LOG2N bits (floor toward minus infinity).
REQ-021 ACC cycle j SHALL add the six products (p_j - mean) * (q_j - mean) to the AW-bit accumulators, using full-width signed differences and products with no truncation.
REQ-022 SCALE SHALL arithmetically shift each accumulator right by LOG2N bits and register the result to the OW-bit covariance outputs.
REQ-023 Latency: if the last point is accepted at edge k, out_valid SHALL rise at edge k+N+2.
REQ-024 While out_valid is high and out_ready is low, all outputs SHALL hold stable.
REQ-025 In the DONE state, out_valid high together with out_ready high SHALL return the FSM to IDLE on the same edge.
REQ-026 start asserted in any state other than IDLE SHALL be ignored.
REQ-027 in_valid asserted outside LOAD SHALL be ignored, and in_ready SHALL be 0 outside LOAD.
REQ-028 Covariance and mean outputs SHALL retain their last results in IDLE and LOAD until the next SCALE or MEAN state overwrites them.

Reset
REQ-029 While rst is 0, the block SHALL asynchronously force:
- state to IDLE;
- in_ready, out_valid and busy to 0;
- all means, covariances, sums, accumulators and counters to 0.
REQ-030 rst deasserting while start is high SHALL NOT begin a set until the first posedge after rst is high.
REQ-031 Reset asserted mid-operation (LOAD, ACC or DONE) SHALL abort the set with no partial result presented.
REQ-032 Point buffer contents need no reset value.

Verification
REQ-033 Test 1, constant points: start, then 16 points (1,2,3) -> means 1, 2, 3; all six covariance terms 0; out_valid at edge k+18.
REQ-034 Test 2, ramp: points x=i, y=-i, z=0 for i=0..15 -> mean_x=7, mean_y=-8, mean_z=0; covXX=21, covYY=21, covXY=-21, covXZ=0, covYZ=0, covZZ=0.
REQ-035 Test 3, input stalls: test 2 with in_valid low for 3 cycles after points 4 and 11 -> identical results; in_ready is 0 outside LOAD.
REQ-036 Test 4, output backpressure: hold out_ready low for 10 cycles in DONE -> outputs and out_valid stable; IDLE on the cycle after out_ready is raised; start pulsed during ACC has no effect.
REQ-037 Test 5, reset mid-ACC: assert rst at ACC cycle 5 -> immediate IDLE with all outputs 0; a subsequent test 1 completes correctly.
REQ-038 Test 6, extremes with DW=10 and LOG2N=4: 8 points (-512,-512,-512) and 8 points (511,511,511) -> mean -1; all covariance terms 261632; no overflow.
